idelay_tap_cal: RTL and testbench

Tap-sweep calibration controller for the VAR_LOAD input-delay stage. After IDELAYCTRL reports ready, it loads each tap value 0..31 in turn and waits for the delay to settle. It then qualifies each tap with pass/error reports from the downstream pattern checker. Finally it finds the longest contiguous passing window and loads its centre tap, leaving the delay line parked there.

---
 rtl/idelay_tap_cal_if.sv | 30 +++
 rtl/idelay_tap_cal.sv | 202 ++++++++++++++++++++
 tb/tb_idelay_tap_cal.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/idelay_tap_cal_if.sv
// idelay_tap_cal_if: control and status bundle between the tap-sweep
// calibration controller and its environment (checker, delay stage, host).
//   master : controller side (drives load/status, receives start/rdy/checker)
//   slave  : environment side
interface idelay_tap_cal_if;
  logic        start;
  logic        rdy;
  logic        chk_valid;
  logic        chk_err;
  logic        ld;
  logic [4:0]  cntvaluein;
  logic        ce;
  logic        inc;
  logic        busy;
  logic        done;
  logic        fail;
  logic [4:0]  best_tap;
  logic [5:0]  win_len;
  logic [31:0] pass_map;

  modport master (
    input  start, rdy, chk_valid, chk_err,
    output ld, cntvaluein, ce, inc, busy, done, fail, best_tap, win_len, pass_map
  );

  modport slave (
    output start, rdy, chk_valid, chk_err,
    input  ld, cntvaluein, ce, inc, busy, done, fail, best_tap, win_len, pass_map
  );
endinterface

// File: rtl/idelay_tap_cal.sv
// idelay_tap_cal: tap-sweep calibration for a VAR_LOAD input delay.
// Loads taps 0..31, waits SETTLE_CYC cycles, qualifies each tap with
// SAMPLES error-free checker samples (any error fails it at once), then
// loads the centre of the longest contiguous passing window.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus.start  : begin calibration (honoured in IDLE/DONE only)
//   bus.rdy    : IDELAYCTRL ready; loss mid-sweep restarts the sweep
//   bus.chk_valid / bus.chk_err : pattern checker sample and mismatch flag
//   bus.ld / bus.cntvaluein      : load strobe and tap value
//   bus.ce / bus.inc             : tied low
//   bus.busy / bus.done / bus.fail, bus.best_tap, bus.win_len, bus.pass_map : status
module idelay_tap_cal #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SAMPLES    = 64,
  parameter int unsigned MIN_WIN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  idelay_tap_cal_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_FINAL_LD, S_DONE
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLES - 1);
  localparam logic [5:0]  MIN_LEN     = 6'(MIN_WIN);

  state_t      r_state;
  logic [4:0]  r_tap;
  logic [7:0]  r_settle;
  logic [15:0] r_samp;
  logic        r_tap_pass;
  logic [5:0]  r_run_len;
  logic [4:0]  r_run_start;
  logic [5:0]  r_best_len;
  logic [4:0]  r_best_start;

  logic        r_ld;
  logic [4:0]  r_cntval;
  logic        r_busy;
  logic        r_done;
  logic        r_fail;
  logic [4:0]  r_best_tap;
  logic [5:0]  r_win_len;
  logic [31:0] r_pass_map;

  logic [5:0]  w_run_len_nx;
  logic [4:0]  w_run_start_nx;
  logic [5:0]  w_best_len_nx;
  logic [4:0]  w_best_start_nx;
  logic [4:0]  w_centre;
  logic [4:0]  w_final_tap;
  logic        w_abort;

  // Tracker update for the tap just qualified. Evaluated combinationally so
  // that at tap 31 the final load can carry the centre of the updated window.
  always_comb begin
    w_run_len_nx    = '0;
    w_run_start_nx  = r_run_start;
    w_best_len_nx   = r_best_len;
    w_best_start_nx = r_best_start;
    if (r_tap_pass) begin
      w_run_len_nx = r_run_len + 6'd1;
      if (r_run_len == '0) w_run_start_nx = r_tap;
      // Strict compare: the lowest-index window wins ties.
      if (w_run_len_nx > r_best_len) begin
        w_best_len_nx   = w_run_len_nx;
        w_best_start_nx = w_run_start_nx;
      end
    end
    w_centre    = w_best_start_nx + 5'((w_best_len_nx - 6'd1) >> 1);
    w_final_tap = (w_best_len_nx >= MIN_LEN) ? w_centre : '0;
  end

  assign w_abort = !bus.rdy &&
                   (r_state inside {S_LOAD, S_SETTLE, S_CHECK, S_NEXT});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_settle     <= '0;
      r_samp       <= '0;
      r_tap_pass   <= 1'b0;
      r_run_len    <= '0;
      r_run_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
      r_ld         <= 1'b0;
      r_cntval     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_best_tap   <= '0;
      r_win_len    <= '0;
      r_pass_map   <= '0;
    end else begin
      r_ld <= 1'b0;
      if (w_abort) begin
        // cntvaluein is left alone so it stays stable until the next load.
        r_pass_map   <= '0;
        r_run_len    <= '0;
        r_run_start  <= '0;
        r_best_len   <= '0;
        r_best_start <= '0;
        r_tap        <= '0;
        r_state      <= S_WAIT_RDY;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              r_pass_map   <= '0;
              r_win_len    <= '0;
              r_best_tap   <= '0;
              r_done       <= 1'b0;
              r_fail       <= 1'b0;
              r_busy       <= 1'b1;
              r_tap        <= '0;
              r_run_len    <= '0;
              r_run_start  <= '0;
              r_best_len   <= '0;
              r_best_start <= '0;
              r_state      <= S_WAIT_RDY;
            end
          end
          S_WAIT_RDY: begin
            if (bus.rdy) begin
              r_ld     <= 1'b1;
              r_cntval <= r_tap;
              r_state  <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_settle <= '0;
            r_state  <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_settle == SETTLE_LAST) begin
              r_samp  <= '0;
              r_state <= S_CHECK;
            end else begin
              r_settle <= r_settle + 8'd1;
            end
          end
          S_CHECK: begin
            if (bus.chk_valid) begin
              if (bus.chk_err) begin
                r_tap_pass <= 1'b0;
                r_state    <= S_NEXT;
              end else if (r_samp == SAMPLE_LAST) begin
                r_tap_pass        <= 1'b1;
                r_pass_map[r_tap] <= 1'b1;
                r_state           <= S_NEXT;
              end else begin
                r_samp <= r_samp + 16'd1;
              end
            end
          end
          S_NEXT: begin
            r_run_len    <= w_run_len_nx;
            r_run_start  <= w_run_start_nx;
            r_best_len   <= w_best_len_nx;
            r_best_start <= w_best_start_nx;
            r_ld         <= 1'b1;
            if (r_tap == 5'd31) begin
              r_cntval <= w_final_tap;
              r_state  <= S_FINAL_LD;
            end else begin
              r_tap    <= r_tap + 5'd1;
              r_cntval <= r_tap + 5'd1;
              r_state  <= S_LOAD;
            end
          end
          S_FINAL_LD: begin
            r_best_tap <= r_cntval;
            r_win_len  <= r_best_len;
            r_fail     <= (r_best_len < MIN_LEN);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ld         = r_ld;
  assign bus.cntvaluein = r_cntval;
  assign bus.ce         = 1'b0;
  assign bus.inc        = 1'b0;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.best_tap   = r_best_tap;
  assign bus.win_len    = r_win_len;
  assign bus.pass_map   = r_pass_map;

endmodule

// File: tb/tb_idelay_tap_cal.sv
module tb_idelay_tap_cal;
  localparam int SETTLE = 4;
  localparam int NSAMP  = 5;
  localparam int MINW   = 4;

  typedef struct {int val; int sp;} ld_t;

  logic clk;
  logic rst;
  idelay_tap_cal_if bus();

  idelay_tap_cal #(.SETTLE_CYC(SETTLE), .SAMPLES(NSAMP), .MIN_WIN(MINW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_ld_cyc = 0;
  int n_ld = 0;
  int hold_val = 0;
  bit mon_en = 1'b0;
  logic [31:0] pass_mask = '0;
  bit gap_mode = 1'b0;
  ld_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Cycles from one load to the next, given the previous tap's outcome.
  function automatic int tap_dur(bit p, bit gap);
    if (!p) return SETTLE + 3;
    return gap ? SETTLE + 3 * NSAMP : SETTLE + NSAMP + 2;
  endfunction

  // Expected load sequence: taps 0..31 then the centre of the longest
  // lowest-index all-ones window (found by exhaustive search).
  task automatic build_model(input logic [31:0] mask, input bit gap, input int first_sp);
    int bl, bs, ctr;
    bit ok;
    bl = 0; bs = 0;
    for (int len = 32; len >= 1; len--) begin
      for (int s = 0; s + len <= 32; s++) begin
        if (bl == 0) begin
          ok = 1'b1;
          for (int j = s; j < s + len; j++) if (!mask[j]) ok = 1'b0;
          if (ok) begin bl = len; bs = s; end
        end
      end
    end
    ctr = (bl >= MINW) ? bs + (bl - 1) / 2 : 0;
    exp_q.delete();
    for (int t = 0; t <= 32; t++) begin
      ld_t e;
      e.val = (t < 32) ? t : ctr;
      e.sp  = (t == 0) ? first_sp : tap_dur(mask[t-1], gap);
      exp_q.push_back(e);
    end
    pass_mask = mask;
    gap_mode  = gap;
  endtask

  // Pattern checker stand-in: garbage errors during settle, then the tap's verdict.
  int k = 1000;
  int r_tap = 0;
  always @(negedge clk) begin
    if (bus.ld) begin
      r_tap = int'(bus.cntvaluein);
      k = 0;
    end else if (k < 1000) begin
      k++;
    end
    if (rst || k == 0) begin
      bus.chk_valid = 1'b0; bus.chk_err = 1'b0;
    end else if (k <= SETTLE) begin
      bus.chk_valid = 1'b1; bus.chk_err = 1'b1;
    end else if (gap_mode && ((k - SETTLE - 1) % 3) != 0) begin
      bus.chk_valid = 1'b0; bus.chk_err = 1'b1;
    end else begin
      bus.chk_valid = 1'b1; bus.chk_err = !pass_mask[r_tap];
    end
  end

  // Compare process: every cycle, loads against the model sequence and timing.
  always @(negedge clk) begin
    if (!rst) begin
      check("ce_tied", int'(bus.ce), 0);
      check("inc_tied", int'(bus.inc), 0);
    end
    if (mon_en && !rst) begin
      if (bus.ld) begin
        n_ld++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL ld_unexpected: got ld with %0d expected none", int'(bus.cntvaluein));
        end else begin
          ld_t e;
          e = exp_q.pop_front();
          check("ld_val", int'(bus.cntvaluein), e.val);
          if (e.sp > 0) check("ld_spacing", cyc - last_ld_cyc, e.sp);
        end
        last_ld_cyc = cyc;
        hold_val = int'(bus.cntvaluein);
      end else begin
        check("cnt_hold", int'(bus.cntvaluein), hold_val);
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_ld"}, int'(bus.ld), 0);
    check({tag, "_cnt"}, int'(bus.cntvaluein), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_fail"}, int'(bus.fail), 0);
    check({tag, "_best"}, int'(bus.best_tap), 0);
    check({tag, "_win"}, int'(bus.win_len), 0);
    check({tag, "_map"}, int'(bus.pass_map), 0);
  endtask

  task automatic begin_run(input logic [31:0] mask, input bit gap);
    build_model(mask, gap, 2);
    @(negedge clk);
    bus.start = 1'b1;
    last_ld_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", int'(bus.busy), 1);
    check("done_clr", int'(bus.done), 0);
    check("map_clr", int'(bus.pass_map), 0);
  endtask

  task automatic wait_ld(input int t);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.ld && int'(bus.cntvaluein) == t) seen = 1'b1;
    end
    check("wait_ld_seen", int'(seen), 1);
  endtask

  task automatic end_run(input logic [31:0] mask, input int ewin, input int etap, input int efail);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    check("done_after_ld", cyc - last_ld_cyc, 1);
    check("all_loads_seen", exp_q.size(), 0);
    check("busy_fall", int'(bus.busy), 0);
    check("fail", int'(bus.fail), efail);
    check("win_len", int'(bus.win_len), ewin);
    check("best_tap", int'(bus.best_tap), etap);
    check("parked_tap", int'(bus.cntvaluein), etap);
    check("pass_map", int'(bus.pass_map), int'(mask));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.rdy = 1'b1;
    bus.chk_valid = 1'b0;
    bus.chk_err = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single window 10..19
    begin_run(32'h000FFC00, 1'b0);
    end_run(32'h000FFC00, 10, 14, 0);

    // Two windows, the longer one wins
    begin_run(32'h0003F078, 1'b0);
    end_run(32'h0003F078, 6, 14, 0);

    // Equal windows: lowest index wins
    begin_run(32'h00F0003C, 1'b0);
    end_run(32'h00F0003C, 4, 3, 0);

    // Nothing passes
    begin_run(32'h00000000, 1'b0);
    end_run(32'h00000000, 0, 0, 1);

    // Window shorter than MIN_WIN
    begin_run(32'h00000007, 1'b0);
    end_run(32'h00000007, 3, 0, 1);

    // Everything passes: 33 loads
    ld0 = n_ld;
    begin_run(32'hFFFFFFFF, 1'b0);
    end_run(32'hFFFFFFFF, 32, 15, 0);
    check("ld_count", n_ld - ld0, 33);

    // Sparse checker samples; a start mid-sweep is ignored
    begin_run(32'h000FFC00, 1'b1);
    wait_ld(5);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("start_ignored_busy", int'(bus.busy), 1);
    end_run(32'h000FFC00, 10, 14, 0);
    gap_mode = 1'b0;

    // rdy drop during CHECK of tap 7
    begin_run(32'hFFFFFFFF, 1'b0);
    wait_ld(7);
    repeat (SETTLE + 1) @(negedge clk);
    bus.rdy = 1'b0;
    build_model(32'hFFFFFFFF, 1'b0, 1);
    repeat (2) @(negedge clk);
    check("abort_map_clr", int'(bus.pass_map), 0);
    check("abort_busy", int'(bus.busy), 1);
    repeat (3) @(negedge clk);
    bus.rdy = 1'b1;
    last_ld_cyc = cyc;
    end_run(32'hFFFFFFFF, 32, 15, 0);
    // rdy loss in DONE is ignored
    bus.rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("done_rdy_hold", int'(bus.done), 1);
    check("done_rdy_map", int'(bus.pass_map), 32'hFFFFFFFF);
    bus.rdy = 1'b1;

    // Reset during tap 20
    begin_run(32'h000FFC00, 1'b0);
    wait_ld(20);
    @(negedge clk) mon_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_next");
    rst = 1'b0;
    exp_q.delete();
    hold_val = 0;
    // start coincident with reset is lost
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_rst_lost", int'(bus.busy), 0);
    mon_en = 1'b1;
    begin_run(32'h000FFC00, 1'b0);
    end_run(32'h000FFC00, 10, 14, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
